booth_mul_seq: RTL

- Iterative radix-4 Booth multiplier with valid/ready handshakes on input and output.
- Retires one Booth digit per cycle, so area is far below the fully combinational partial-product-array multiplier. Used on DCSK correlator/mixer paths where throughput is low.
- Adds a runtime signed/unsigned mode select. Result is the exact 2*WORD_LEN-bit product in both modes.

---
 rtl/booth_mul_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, with runtime signed/unsigned mode.
// Optional early termination when the remaining multiplier digits are all zero: define BOOTH_MUL_SEQ_EARLY_TERM_EN.
module booth_mul_seq #(
  parameter int WORD_LEN = 8
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_signed,
  input  logic [WORD_LEN-1:0]       i_multiplier,
  input  logic [WORD_LEN-1:0]       i_multiplicand,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2*WORD_LEN-1:0]     o_result
);

  localparam int EXT  = WORD_LEN + 2;
  localparam int NDIG = EXT / 2;
  localparam int AW   = 2 * EXT;
  localparam int KW   = $clog2(NDIG + 1);
  localparam int SW   = KW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (((WORD_LEN % 2) != 0) || (WORD_LEN < 4)) begin : gBadWordLen
    $error("booth_mul_seq: WORD_LEN must be even and >= 4");
  end

  logic [1:0]     state_q,  state_d;
  logic [EXT-1:0] mcand_q,  mcand_d;
  logic [EXT:0]   mplier_q, mplier_d;
  logic [AW-1:0]  acc_q,    acc_d;
  logic [KW-1:0]  digit_q,  digit_d;

  logic           accept;
  logic           earlyStop;
  logic [EXT-1:0] mcandExt;
  logic [EXT-1:0] mplierExt;
  logic [AW-1:0]  mcandWide;
  logic [AW-1:0]  ppMag;
  logic [AW-1:0]  ppShift;
  logic [AW-1:0]  addend;
  logic           ppNeg;
  logic [SW-1:0]  shamt;

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = acc_q[2*WORD_LEN-1:0];
  assign accept   = i_valid && (state_q == IDLE);

  // Two extra bits let unsigned operands be recoded as non-negative signed values.
  assign mcandExt  = i_signed ? {{2{i_multiplicand[WORD_LEN-1]}}, i_multiplicand}
                              : {2'b00, i_multiplicand};
  assign mplierExt = i_signed ? {{2{i_multiplier[WORD_LEN-1]}}, i_multiplier}
                              : {2'b00, i_multiplier};
  assign mcandWide = {{EXT{mcand_q[EXT-1]}}, mcand_q};

`ifdef BOOTH_MUL_SEQ_EARLY_TERM_EN
  assign earlyStop = (&mplier_q) | ~(|mplier_q);
`else
  assign earlyStop = 1'b0;
`endif

  always_comb begin
    ppMag = '0;
    ppNeg = 1'b0;
    case (mplier_q[2:0])
      3'b001, 3'b010: ppMag = mcandWide;
      3'b011:         ppMag = mcandWide << 1;
      3'b100: begin
        ppMag = mcandWide << 1;
        ppNeg = 1'b1;
      end
      3'b101, 3'b110: begin
        ppMag = mcandWide;
        ppNeg = 1'b1;
      end
      default:        ppMag = '0;
    endcase
  end

  // Negation is folded into the accumulator add as invert plus carry-in.
  assign shamt   = {digit_q, 1'b0};
  assign ppShift = ppMag << shamt;
  assign addend  = ppNeg ? ~ppShift : ppShift;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    digit_d  = digit_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = mcandExt;
          mplier_d = {mplierExt, 1'b0};
          acc_d    = '0;
          digit_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (earlyStop) begin
          state_d = DONE;
        end else begin
          acc_d    = acc_q + addend + AW'(ppNeg);
          mplier_d = {{2{mplier_q[EXT]}}, mplier_q[EXT:2]};
          digit_d  = digit_q + KW'(1);
          if (digit_q == KW'(NDIG - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      digit_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      digit_q  <= digit_d;
    end
  end

endmodule
